// File: rtl/rom_arbiter_if.sv
// Bus bundle between the fetch/data ports, the shared ROM and the rom_arbiter.
// The master side drives requests and ROM data; the arbiter drives responses and the ROM strobe.
interface rom_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic [DATA_W-1:0] if_inst;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_data;

   logic              rom_ce;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;

   logic              stall_req;

   modport master (
      output if_req, if_addr, mem_req, mem_addr, rom_data,
      input  if_ready, if_inst, mem_ready, mem_data, rom_ce, rom_addr, stall_req
   );

   modport slave (
      input  if_req, if_addr, mem_req, mem_addr, rom_data,
      output if_ready, if_inst, mem_ready, mem_data, rom_ce, rom_addr, stall_req
   );

endinterface

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single combinational ROM: one access in flight,
// alternating grant under contention, fixed WAIT_CYCLES access time.
module rom_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input logic          clk,
   input logic          rst,
   rom_arbiter_if.slave bus
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              gnt_mem_q, gnt_mem_d;
   logic              last_mem_q, last_mem_d;
   logic              rom_ce_q, rom_ce_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              if_ready_q, if_ready_d;
   logic [DATA_W-1:0] if_inst_q, if_inst_d;
   logic              mem_ready_q, mem_ready_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;

   logic              any_req_c;
   logic              pick_mem_c;

   // Mem wins contention unless it was the last port served.
   assign any_req_c  = bus.if_req | bus.mem_req;
   assign pick_mem_c = bus.mem_req & (~bus.if_req | ~last_mem_q);

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         gnt_mem_q   <= 1'b0;
         last_mem_q  <= 1'b0;
         rom_ce_q    <= 1'b0;
         rom_addr_q  <= '0;
         if_ready_q  <= 1'b0;
         if_inst_q   <= '0;
         mem_ready_q <= 1'b0;
         mem_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_mem_q   <= gnt_mem_d;
         last_mem_q  <= last_mem_d;
         rom_ce_q    <= rom_ce_d;
         rom_addr_q  <= rom_addr_d;
         if_ready_q  <= if_ready_d;
         if_inst_q   <= if_inst_d;
         mem_ready_q <= mem_ready_d;
         mem_data_q  <= mem_data_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (any_req_c) state_d = S_ACCESS;
         S_ACCESS: if (cnt_q == '0) state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      cnt_d       = cnt_q;
      gnt_mem_d   = gnt_mem_q;
      last_mem_d  = last_mem_q;
      rom_ce_d    = rom_ce_q;
      rom_addr_d  = rom_addr_q;
      if_ready_d  = 1'b0;
      if_inst_d   = if_inst_q;
      mem_ready_d = 1'b0;
      mem_data_d  = mem_data_q;

      unique case (state_q)
         S_IDLE: begin
            rom_ce_d = 1'b0;
            if (any_req_c) begin
               gnt_mem_d  = pick_mem_c;
               last_mem_d = pick_mem_c;
               rom_addr_d = pick_mem_c ? bus.mem_addr : bus.if_addr;
               cnt_d      = CNT_W'(WAIT_CYCLES - 1);
               rom_ce_d   = 1'b1;
            end
         end
         S_ACCESS: begin
            if (cnt_q == '0) begin
               rom_ce_d = 1'b0;
               if (gnt_mem_q) begin
                  mem_data_d  = bus.rom_data;
                  mem_ready_d = 1'b1;
               end else begin
                  if_inst_d  = bus.rom_data;
                  if_ready_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            rom_ce_d = 1'b0;
         end
         default: begin
            rom_ce_d = 1'b0;
         end
      endcase
   end

   assign bus.rom_ce    = rom_ce_q;
   assign bus.rom_addr  = rom_addr_q;
   assign bus.if_ready  = if_ready_q;
   assign bus.if_inst   = if_inst_q;
   assign bus.mem_ready = mem_ready_q;
   assign bus.mem_data  = mem_data_q;
   assign bus.stall_req = (bus.if_req & ~if_ready_q) | (bus.mem_req & ~mem_ready_q);

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: three instances (WAIT_CYCLES 1, 2, 3) on a shared ROM model,
// directed timing scenarios plus randomized traffic with per-port expected-word queues.
module tb_rom_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [31:0] q_if  [$];
   logic [31:0] q_mem [$];

   always #5 clk = ~clk;

   rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
   rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
   rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

   rom_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
   rom_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
   rom_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

   function automatic logic [31:0] rom_fn(input logic [31:0] a);
      logic [31:0] idx;
      idx = a >> 2;
      if (idx == 32'd1) return 32'h3401_1100;
      return 32'hA500_5A5A ^ (idx * 32'h0001_0203);
   endfunction

   assign b1.rom_data = rom_fn(b1.rom_addr);
   assign b2.rom_data = rom_fn(b2.rom_addr);
   assign b3.rom_data = rom_fn(b3.rom_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      b1.if_req = 0; b1.mem_req = 0; b1.if_addr = '0; b1.mem_addr = '0;
      b2.if_req = 0; b2.mem_req = 0; b2.if_addr = '0; b2.mem_addr = '0;
      b3.if_req = 0; b3.mem_req = 0; b3.if_addr = '0; b3.mem_addr = '0;
      rst = 1'b1;
      tick();
      n_cmp++; if (b1.rom_ce !== 1'b0)    begin n_bad++; $display("FAIL reset_rom_ce got %b want 0", b1.rom_ce); end
      n_cmp++; if (b1.rom_addr !== '0)    begin n_bad++; $display("FAIL reset_rom_addr got %h want 0", b1.rom_addr); end
      n_cmp++; if (b1.if_ready !== 1'b0)  begin n_bad++; $display("FAIL reset_if_ready got %b want 0", b1.if_ready); end
      n_cmp++; if (b1.mem_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mem_ready got %b want 0", b1.mem_ready); end
      n_cmp++; if (b1.if_inst !== '0)     begin n_bad++; $display("FAIL reset_if_inst got %h want 0", b1.if_inst); end
      n_cmp++; if (b1.mem_data !== '0)    begin n_bad++; $display("FAIL reset_mem_data got %h want 0", b1.mem_data); end
      n_cmp++; if (b1.stall_req !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", b1.stall_req); end
      tick();
      rst = 1'b0;
      tick();
      n_cmp++; if (b1.rom_ce !== 1'b0)    begin n_bad++; $display("FAIL idle_rom_ce got %b want 0", b1.rom_ce); end
   endtask

   // WAIT_CYCLES=1 single fetch of ROM word 1.
   task automatic test_basic_fetch();
      logic [31:0] exp;
      b1.if_addr = 32'h4; b1.if_req = 1'b1; q_if.push_back(32'h3401_1100);
      #1;
      n_cmp++; if (b1.stall_req !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_c0 got %b want 1", b1.stall_req); end
      tick();
      n_cmp++; if (b1.rom_ce !== 1'b1)    begin n_bad++; $display("FAIL fetch_rom_ce_c1 got %b want 1", b1.rom_ce); end
      n_cmp++; if (b1.rom_addr !== 32'h4) begin n_bad++; $display("FAIL fetch_rom_addr_c1 got %h want 4", b1.rom_addr); end
      n_cmp++; if (b1.if_ready !== 1'b0)  begin n_bad++; $display("FAIL fetch_ready_c1 got %b want 0", b1.if_ready); end
      tick();
      exp = q_if.pop_front();
      n_cmp++; if (b1.if_ready !== 1'b1)  begin n_bad++; $display("FAIL fetch_ready_c2 got %b want 1", b1.if_ready); end
      n_cmp++; if (b1.if_inst !== exp)    begin n_bad++; $display("FAIL fetch_inst_c2 got %h want %h", b1.if_inst, exp); end
      n_cmp++; if (b1.mem_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_mem_ready_c2 got %b want 0", b1.mem_ready); end
      n_cmp++; if (b1.rom_ce !== 1'b0)    begin n_bad++; $display("FAIL fetch_rom_ce_c2 got %b want 0", b1.rom_ce); end
      n_cmp++; if (b1.stall_req !== 1'b0) begin n_bad++; $display("FAIL fetch_stall_c2 got %b want 0", b1.stall_req); end
      b1.if_req = 1'b0;
      tick();
      n_cmp++; if (b1.if_ready !== 1'b0)  begin n_bad++; $display("FAIL fetch_ready_c3 got %b want 0", b1.if_ready); end
   endtask

   // Both ports held after reset: mem first, then alternation.
   task automatic test_contention();
      logic [31:0] exp;
      logic        want_if, want_mem;
      do_reset();
      b1.if_addr = 32'h0; b1.mem_addr = 32'h8;
      b1.if_req = 1'b1; b1.mem_req = 1'b1;
      repeat (2) begin q_if.push_back(rom_fn(32'h0)); q_mem.push_back(rom_fn(32'h8)); end
      for (int c = 1; c <= 12; c++) begin
         tick();
         want_if  = (c == 5) || (c == 11);
         want_mem = (c == 2) || (c == 8);
         n_cmp++; if (b1.if_ready !== want_if)   begin n_bad++; $display("FAIL contend_if_ready c%0d got %b want %b", c, b1.if_ready, want_if); end
         n_cmp++; if (b1.mem_ready !== want_mem) begin n_bad++; $display("FAIL contend_mem_ready c%0d got %b want %b", c, b1.mem_ready, want_mem); end
         if (want_if && q_if.size() > 0) begin
            exp = q_if.pop_front();
            n_cmp++; if (b1.if_inst !== exp) begin n_bad++; $display("FAIL contend_if_inst c%0d got %h want %h", c, b1.if_inst, exp); end
         end
         if (want_mem && q_mem.size() > 0) begin
            exp = q_mem.pop_front();
            n_cmp++; if (b1.mem_data !== exp) begin n_bad++; $display("FAIL contend_mem_data c%0d got %h want %h", c, b1.mem_data, exp); end
         end
      end
      b1.if_req = 1'b0; b1.mem_req = 1'b0;
      tick(); tick(); tick();
      q_if.delete(); q_mem.delete();
   endtask

   // WAIT_CYCLES=3: address held through ACCESS even if the port changes it.
   task automatic test_wait3();
      logic [31:0] exp;
      b3.mem_addr = 32'h10; b3.mem_req = 1'b1; q_mem.push_back(rom_fn(32'h10));
      for (int c = 1; c <= 3; c++) begin
         tick();
         n_cmp++; if (b3.rom_ce !== 1'b1)     begin n_bad++; $display("FAIL w3_rom_ce c%0d got %b want 1", c, b3.rom_ce); end
         n_cmp++; if (b3.rom_addr !== 32'h10) begin n_bad++; $display("FAIL w3_rom_addr c%0d got %h want 10", c, b3.rom_addr); end
         n_cmp++; if (b3.mem_ready !== 1'b0)  begin n_bad++; $display("FAIL w3_mem_ready c%0d got %b want 0", c, b3.mem_ready); end
         if (c == 2) b3.mem_addr = 32'h20;
      end
      tick();
      exp = q_mem.pop_front();
      n_cmp++; if (b3.mem_ready !== 1'b1) begin n_bad++; $display("FAIL w3_mem_ready c4 got %b want 1", b3.mem_ready); end
      n_cmp++; if (b3.mem_data !== exp)   begin n_bad++; $display("FAIL w3_mem_data c4 got %h want %h", b3.mem_data, exp); end
      n_cmp++; if (b3.rom_ce !== 1'b0)    begin n_bad++; $display("FAIL w3_rom_ce c4 got %b want 0", b3.rom_ce); end
      n_cmp++; if (b3.if_ready !== 1'b0)  begin n_bad++; $display("FAIL w3_if_ready c4 got %b want 0", b3.if_ready); end
      b3.mem_req = 1'b0;
      tick();
      n_cmp++; if (b3.mem_ready !== 1'b0) begin n_bad++; $display("FAIL w3_mem_ready c5 got %b want 0", b3.mem_ready); end
   endtask

   // WAIT_CYCLES=2: request dropped in ACCESS still completes.
   task automatic test_drop();
      logic [31:0] exp;
      b2.if_addr = 32'h1C; b2.if_req = 1'b1; q_if.push_back(rom_fn(32'h1C));
      tick();
      n_cmp++; if (b2.rom_ce !== 1'b1) begin n_bad++; $display("FAIL drop_rom_ce c1 got %b want 1", b2.rom_ce); end
      b2.if_req = 1'b0;
      #1;
      n_cmp++; if (b2.stall_req !== 1'b0) begin n_bad++; $display("FAIL drop_stall c1 got %b want 0", b2.stall_req); end
      tick();
      n_cmp++; if (b2.if_ready !== 1'b0) begin n_bad++; $display("FAIL drop_ready c2 got %b want 0", b2.if_ready); end
      tick();
      exp = q_if.pop_front();
      n_cmp++; if (b2.if_ready !== 1'b1) begin n_bad++; $display("FAIL drop_ready c3 got %b want 1", b2.if_ready); end
      n_cmp++; if (b2.if_inst !== exp)   begin n_bad++; $display("FAIL drop_inst c3 got %h want %h", b2.if_inst, exp); end
      tick();
      n_cmp++; if (b2.if_ready !== 1'b0) begin n_bad++; $display("FAIL drop_ready c4 got %b want 0", b2.if_ready); end
   endtask

   // Reset during ACCESS aborts; held request is served again after release.
   task automatic test_reset_abort();
      logic [31:0] exp;
      logic        want;
      b3.if_addr = 32'h24; b3.if_req = 1'b1; q_if.push_back(rom_fn(32'h24));
      tick();
      n_cmp++; if (b3.rom_ce !== 1'b1) begin n_bad++; $display("FAIL abort_rom_ce c1 got %b want 1", b3.rom_ce); end
      rst = 1'b1;
      #1;
      n_cmp++; if (b3.rom_ce !== 1'b0)   begin n_bad++; $display("FAIL abort_rom_ce_rst got %b want 0", b3.rom_ce); end
      n_cmp++; if (b3.rom_addr !== '0)   begin n_bad++; $display("FAIL abort_rom_addr_rst got %h want 0", b3.rom_addr); end
      n_cmp++; if (b3.mem_data !== '0)   begin n_bad++; $display("FAIL abort_mem_data_rst got %h want 0", b3.mem_data); end
      n_cmp++; if (b3.if_inst !== '0)    begin n_bad++; $display("FAIL abort_if_inst_rst got %h want 0", b3.if_inst); end
      for (int c = 0; c < 2; c++) begin
         tick();
         n_cmp++; if (b3.if_ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready_in_rst got %b want 0", b3.if_ready); end
      end
      rst = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         want = (k == 4);
         n_cmp++; if (b3.if_ready !== want) begin n_bad++; $display("FAIL abort_reserve_ready k%0d got %b want %b", k, b3.if_ready, want); end
         if (want) begin
            exp = q_if.pop_front();
            n_cmp++; if (b3.if_inst !== exp) begin n_bad++; $display("FAIL abort_reserve_inst got %h want %h", b3.if_inst, exp); end
         end
      end
      b3.if_req = 1'b0;
      tick(); tick();
   endtask

   // Random traffic on WAIT_CYCLES=1 against per-port scoreboards.
   task automatic test_random();
      logic [31:0] a, exp;
      int          wait_if, wait_mem;
      wait_if = 0; wait_mem = 0;
      q_if.delete(); q_mem.delete();
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (b1.if_ready === 1'b1 || b1.mem_ready === 1'b1) begin
            n_cmp++; if ((b1.if_ready & b1.mem_ready) !== 1'b0) begin n_bad++; $display("FAIL rand_overlap c%0d if=%b mem=%b want not both", c, b1.if_ready, b1.mem_ready); end
         end
         if (b1.if_ready === 1'b1) begin
            n_cmp++;
            if (q_if.size() == 0) begin n_bad++; $display("FAIL rand_if_spurious c%0d got ready want none", c); end
            else begin
               exp = q_if.pop_front();
               if (b1.if_inst !== exp) begin n_bad++; $display("FAIL rand_if_inst c%0d got %h want %h", c, b1.if_inst, exp); end
            end
            n_cmp++; if (wait_if > 12) begin n_bad++; $display("FAIL rand_if_starve waited %0d want <=12", wait_if); end
            b1.if_req = 1'b0; wait_if = 0;
         end else if (b1.if_req) wait_if++;
         if (b1.mem_ready === 1'b1) begin
            n_cmp++;
            if (q_mem.size() == 0) begin n_bad++; $display("FAIL rand_mem_spurious c%0d got ready want none", c); end
            else begin
               exp = q_mem.pop_front();
               if (b1.mem_data !== exp) begin n_bad++; $display("FAIL rand_mem_data c%0d got %h want %h", c, b1.mem_data, exp); end
            end
            n_cmp++; if (wait_mem > 12) begin n_bad++; $display("FAIL rand_mem_starve waited %0d want <=12", wait_mem); end
            b1.mem_req = 1'b0; wait_mem = 0;
         end else if (b1.mem_req) wait_mem++;
         if (c < 2900) begin
            if (!b1.if_req && $urandom_range(0, 2) == 0) begin
               a = 32'($urandom_range(0, 63)) << 2;
               b1.if_addr = a; q_if.push_back(rom_fn(a)); b1.if_req = 1'b1;
            end
            if (!b1.mem_req && $urandom_range(0, 2) == 0) begin
               a = 32'($urandom_range(0, 63)) << 2;
               b1.mem_addr = a; q_mem.push_back(rom_fn(a)); b1.mem_req = 1'b1;
            end
         end
      end
      n_cmp++; if (q_if.size() != 0)  begin n_bad++; $display("FAIL rand_if_drain got %0d pending want 0", q_if.size()); end
      n_cmp++; if (q_mem.size() != 0) begin n_bad++; $display("FAIL rand_mem_drain got %0d pending want 0", q_mem.size()); end
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_contention();
      test_wait3();
      test_drop();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: width of all address ports.
REQ-002 Parameter DATA_W, default 32: width of all data ports.
REQ-003 Parameter WAIT_CYCLES, default 1, legal range 1..15: number of cycles rom_ce/rom_addr are held before rom_data is sampled.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 if_req  input  1  fetch-port request; held high with if_addr stable until if_ready.
REQ-007 if_addr  input  ADDR_W  fetch byte address.
REQ-008 if_ready  output  1  one-cycle pulse: if_inst valid.
REQ-009 if_inst  output  DATA_W  fetched word, registered.
REQ-010 mem_req  input  1  data-port (constant load) request; same protocol as if_req.
REQ-011 mem_addr  input  ADDR_W  data-port byte address.
REQ-012 mem_ready  output  1  one-cycle pulse: mem_data valid.
REQ-013 mem_data  output  DATA_W  loaded word, registered.
REQ-014 rom_ce  output  1  ROM chip enable, active high.
REQ-015 rom_addr  output  ADDR_W  ROM byte address, forwarded unchanged (no alignment check).
REQ-016 rom_data  input  DATA_W  ROM read data, combinational from rom_ce/rom_addr.
REQ-017 stall_req  output  1  pipeline stall request.

Function
REQ-018 The block SHALL implement states IDLE, ACCESS, RESP; exactly one ROM access in flight.
REQ-019 In IDLE with no request, the block SHALL stay in IDLE with rom_ce=0.
REQ-020 In IDLE with one request high, the block SHALL grant it, register its address into rom_addr, load wait counter with WAIT_CYCLES-1, enter ACCESS.
REQ-021 In IDLE with both requests high, the block SHALL grant mem unless last_grant==mem, then grant if (alternating); last_grant updates on every grant.
REQ-022 In ACCESS, rom_ce SHALL be 1 and rom_addr constant; counter decrements each cycle.
REQ-023 In ACCESS with counter==0, the block SHALL capture rom_data into the granted port's data register and enter RESP.
REQ-024 In RESP, only the granted port's ready SHALL be 1 for exactly that cycle; rom_ce=0; requests are not sampled; next state IDLE.
REQ-025 Latency: request high in IDLE cycle 0 -> ready high in cycle WAIT_CYCLES+1; peak throughput one access per WAIT_CYCLES+2 cycles.
REQ-026 Non-granted port's data register SHALL hold its previous value; if_ready and mem_ready SHALL never be high together.
REQ-027 Request dropped during ACCESS: access SHALL complete and ready still pulse; data register updated.
REQ-028 Address change during ACCESS SHALL be ignored; rom_addr keeps the granted address.
REQ-029 stall_req SHALL equal (if_req & ~if_ready) | (mem_req & ~mem_ready), combinational.
REQ-030 Request newly asserted during ACCESS or RESP SHALL be served from the following IDLE, not lost.

Reset
REQ-031 On rst high, asynchronously: state=IDLE, counter=0, last_grant=if (mem wins first contention), rom_ce=0, rom_addr=0, if_ready=0, mem_ready=0, if_inst=0, mem_data=0.
REQ-032 Reset mid-ACCESS SHALL abort the access with no ready pulse; after release, pending requests are re-arbitrated from IDLE.

Verification
REQ-033 WAIT_CYCLES=1, if_req=1, if_addr=0x4, ROM[1]=0x34011100 -> rom_ce=1 cycle 1, if_ready=1 and if_inst=0x34011100 cycle 2.
REQ-034 Both requests held, if_addr=0x0, mem_addr=0x8 after reset -> mem served first (mem_ready cycle 2), if served next (if_ready cycle 5), alternating thereafter.
REQ-035 WAIT_CYCLES=3, mem_req=1 -> rom_ce high cycles 1-3, rom_addr stable, mem_ready cycle 4; mem_addr changed in cycle 2 has no effect.
REQ-036 if_req dropped cycle 1 with WAIT_CYCLES=2 -> if_ready still pulses cycle 3; stall_req 0 from cycle 1.
REQ-037 rst pulsed in ACCESS -> rom_ce, ready, data outputs 0 immediately; no ready pulse; held request re-served, ready WAIT_CYCLES+1 cycles after rst release.
REQ-038 Random req/addr traffic vs. reference model -> ready pulses never overlap, no request starves, every returned word matches ROM at granted address.
